sel_onehot_scan: RTL and testbench

//  Parametrised one-hot channel selector with a registered output, for channel/strobe select.

---
 rtl/sel_onehot_scan_if.sv | 34 +++
 rtl/sel_onehot_scan.sv | 122 ++++++++++++
 tb/tb_sel_onehot_scan.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sel_onehot_scan_if.sv
// Bus bundle for sel_onehot_scan: control inputs, serial data and registered select outputs.
// zo_oe is present only when SEL_ONEHOT_OE_EN is defined.
interface sel_onehot_scan_if #(
  parameter int NCH = 4,
  parameter int SW  = 2
);
  logic           en;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           fin;
  logic [NCH-1:0] zo;
  logic [NCH-1:0] dout;
  logic           err;
  logic           wrap;
`ifdef SEL_ONEHOT_OE_EN
  logic           zo_oe;
`endif

  modport master (
    output en, mode, sel, fin,
`ifdef SEL_ONEHOT_OE_EN
    input  zo_oe,
`endif
    input  zo, dout, err, wrap
  );

  modport slave (
    input  en, mode, sel, fin,
`ifdef SEL_ONEHOT_OE_EN
    output zo_oe,
`endif
    output zo, dout, err, wrap
  );
endinterface

// File: rtl/sel_onehot_scan.sv
// One-hot channel selector: direct decode or dwell-timed scan, with per-channel capture of fin.
// SEL_ONEHOT_OE_EN adds a registered zo_oe output for gating external drivers.
//
//  state  | meaning
//  IDLE   | after reset, no channel active
//  DIRECT | zo follows the decoded sel
//  SCAN   | zo follows the internal pointer, stepping every DWELL enabled cycles
module sel_onehot_scan #(
  parameter int NCH   = 4,
  parameter int SW    = 2,
  parameter int DWELL = 1
) (
  input  logic               ck,
  input  logic               res,
  sel_onehot_scan_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam int              CW       = $clog2(DWELL) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0]   PTR_LAST = SW'(NCH - 1);
  localparam logic [SW:0]     NCH_W    = (SW + 1)'(NCH);

  state_t         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] zo_q, zo_d;
  logic [NCH-1:0] dout_q, dout_d;
  logic           err_q, err_d;
  logic           wrap_q, wrap_d;
`ifdef SEL_ONEHOT_OE_EN
  logic           zo_oe_q, zo_oe_d;
`endif

  // Out-of-range indices decode to all-zero, so zo can never go multi-hot.
  function automatic logic [NCH-1:0] onehot(input logic [SW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (idx == SW'(i));
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    zo_d    = zo_q;
    dout_d  = dout_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    if (bus.en) begin
      for (int i = 0; i < NCH; i++) begin
        if (zo_q[i]) dout_d[i] = bus.fin;
      end
      if (bus.mode) begin
        state_d = SCAN;
        err_d   = 1'b0;
        if (state_q != SCAN) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        zo_d = onehot(ptr_d);
      end else begin
        state_d = DIRECT;
        if ({1'b0, bus.sel} < NCH_W) begin
          zo_d  = onehot(bus.sel);
          err_d = 1'b0;
        end else begin
          zo_d  = '0;
          err_d = 1'b1;
        end
      end
    end
`ifdef SEL_ONEHOT_OE_EN
    zo_oe_d = (|zo_d) && (state_d != IDLE);
`endif
  end

  always_ff @(posedge ck) begin
    if (res) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      zo_q    <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef SEL_ONEHOT_OE_EN
      zo_oe_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      zo_q    <= zo_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
`ifdef SEL_ONEHOT_OE_EN
      zo_oe_q <= zo_oe_d;
`endif
    end
  end

  assign bus.zo   = zo_q;
  assign bus.dout = dout_q;
  assign bus.err  = err_q;
  assign bus.wrap = wrap_q;
`ifdef SEL_ONEHOT_OE_EN
  assign bus.zo_oe = zo_oe_q;
`endif
endmodule

// File: tb/tb_sel_onehot_scan.sv
// Directed bench for sel_onehot_scan: a 4-channel DWELL=2 instance and a 3-channel DWELL=1 instance.
module tb_sel_onehot_scan;
  logic ck;
  logic res;
  int   n_pass;
  int   n_total;

  sel_onehot_scan_if #(.NCH(4), .SW(2)) b4 ();
  sel_onehot_scan_if #(.NCH(3), .SW(2)) b3 ();

  sel_onehot_scan #(.NCH(4), .SW(2), .DWELL(2)) dut4 (.ck(ck), .res(res), .bus(b4));
  sel_onehot_scan #(.NCH(3), .SW(2), .DWELL(1)) dut3 (.ck(ck), .res(res), .bus(b3));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  logic [3:0] scan_zo [10];
  logic       scan_wr [10];
  logic [3:0] fin_seq;
  logic [2:0] s3_zo [4];
  logic       s3_wr [4];

  initial begin
    n_pass  = 0;
    n_total = 0;
    scan_zo = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    scan_wr = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    s3_zo   = '{3'b001, 3'b010, 3'b100, 3'b001};
    s3_wr   = '{0, 0, 0, 1};

    // reset overrides en with scan requested
    res = 1'b1;
    b4.en = 1'b1; b4.mode = 1'b1; b4.sel = '0; b4.fin = 1'b0;
    b3.en = 1'b1; b3.mode = 1'b1; b3.sel = '0; b3.fin = 1'b0;
    step(); step();
    res = 1'b0; b4.en = 1'b0; b3.en = 1'b0;
    step();
    chk("rst_zo",   b4.zo,   4'b0000);
    chk("rst_dout", b4.dout, 4'b0000);
    chk("rst_err",  b4.err,  1'b0);
    chk("rst_wrap", b4.wrap, 1'b0);
`ifdef SEL_ONEHOT_OE_EN
    chk("rst_oe",   b4.zo_oe, 1'b0);
`endif

    // direct decode, one cycle latency
    b4.en = 1'b1; b4.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b4.sel = 2'(i);
      step();
      chk($sformatf("dir_zo%0d", i), b4.zo, 4'b0001 << i);
      chk($sformatf("dir_err%0d", i), b4.err, 1'b0);
    end
`ifdef SEL_ONEHOT_OE_EN
    chk("dir_oe", b4.zo_oe, 1'b1);
`endif

    // 3-channel instance: out-of-range select, then DWELL=1 scan
    b4.en = 1'b0;
    b3.en = 1'b1; b3.mode = 1'b0; b3.sel = 2'd3;
    step();
    chk("oor_zo",  b3.zo,  3'b000);
    chk("oor_err", b3.err, 1'b1);
    chk("hold_zo", b4.zo,  4'b1000);
`ifdef SEL_ONEHOT_OE_EN
    chk("oor_oe",  b3.zo_oe, 1'b0);
`endif
    b3.sel = 2'd1;
    step();
    chk("in_zo",  b3.zo,  3'b010);
    chk("in_err", b3.err, 1'b0);
    b3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("s3_zo%0d", i), b3.zo, s3_zo[i]);
      chk($sformatf("s3_wr%0d", i), b3.wrap, s3_wr[i]);
    end
    b3.en = 1'b0;

    // 4-channel DWELL=2 scan entered from DIRECT
    b4.en = 1'b1; b4.mode = 1'b1; b4.fin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("scan_zo%0d", i), b4.zo, scan_zo[i]);
      chk($sformatf("scan_wr%0d", i), b4.wrap, scan_wr[i]);
    end
    chk("scan_dout", b4.dout, 4'b0000);

    // fin high only on the two edges that sample zo=0100
    fin_seq = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      b4.fin = (i >= 3);
      step();
    end
    chk("cap_zo",   b4.zo,   4'b1000);
    chk("cap_dout", b4.dout, 4'b0100);

    // freeze: fin=1 must not be captured, nothing moves
    b4.en = 1'b0; b4.fin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz_zo%0d", i),   b4.zo,   4'b1000);
      chk($sformatf("frz_dout%0d", i), b4.dout, 4'b0100);
      chk($sformatf("frz_wr%0d", i),   b4.wrap, 1'b0);
    end
    b4.en = 1'b1; b4.fin = 1'b0;
    step();
    chk("thaw_zo",   b4.zo,   4'b1000);
    chk("thaw_dout", b4.dout, 4'b0100);
    step();
    chk("thaw_zo2", b4.zo,   4'b0001);
    chk("thaw_wr",  b4.wrap, 1'b1);

    // advance to ptr=2, then reset mid-scan
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_zo", b4.zo, 4'b0100);
    res = 1'b1;
    step();
    chk("mid_rst_zo",   b4.zo,   4'b0000);
    chk("mid_rst_dout", b4.dout, 4'b0000);
    chk("mid_rst_wr",   b4.wrap, 1'b0);
`ifdef SEL_ONEHOT_OE_EN
    chk("mid_rst_oe",   b4.zo_oe, 1'b0);
`endif
    res = 1'b0;
    step();
    chk("rescan_zo0", b4.zo, 4'b0001);
    step();
    chk("rescan_zo1", b4.zo, 4'b0001);
    step();
    chk("rescan_zo2", b4.zo, 4'b0010);
    chk("rescan_wr",  b4.wrap, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
